// File: rtl/joint_array.sv
// Two-stage join pipeline: a header word arms the block, and each accepted vector gets diagonal
// gaps between adjacent rows filled in. Define JOINT_HITCNT_EN to get a registered popcount on hit_count.
module joint_array #(
   parameter int          W       = 38,
   parameter int          ROWS    = 2,
   parameter logic [15:0] HEADER  = 16'hAAAA,
   parameter int          ONESHOT = 1,
   localparam int         N       = ROWS * W,
   localparam int         HCW     = $clog2(ROWS * W + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [15:0]    header_in,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_data,
   output logic           armed,
   output logic [HCW-1:0] hit_count
);

   typedef enum logic {IDLE, ARMED} state_t;

   state_t         state, state_nx;
   logic           taken;
   logic           s1_valid;
   logic [N-1:0]   s1_data;
   logic [N-1:0]   fill;
   logic [N-1:0]   joined;
   logic           hdr_hit, adv, in_fire, out_fire;

   assign hdr_hit  = (header_in == HEADER);
   assign adv      = !out_valid || out_ready;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      armed    = (state == ARMED);
      case (state)
         IDLE: if (hdr_hit) state_nx = ARMED;
         ARMED: begin
            // A one-shot block takes a single vector, then waits for it to leave.
            in_ready = (!s1_valid || adv) && !((ONESHOT != 0) && taken);
            if ((ONESHOT != 0) && out_fire && !hdr_hit) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)           taken <= 1'b0;
      else if (in_fire)  taken <= (ONESHOT != 0);
      else if (out_fire) taken <= 1'b0;
   end

   // Single pass over the stage-1 snapshot; fills never feed further fills.
   always_comb begin
      fill = '0;
      for (int r = 0; r < ROWS - 1; r++) begin
         for (int i = 1; i < W - 1; i++) begin
            if (s1_data[r*W+i] && s1_data[(r+1)*W+i+1]) begin
               fill[r*W+i+1]   = 1'b1;
               fill[(r+1)*W+i] = 1'b1;
            end
            if (s1_data[r*W+i+1] && s1_data[(r+1)*W+i]) begin
               fill[r*W+i]       = 1'b1;
               fill[(r+1)*W+i+1] = 1'b1;
            end
         end
      end
   end

   assign joined = s1_data | fill;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
         end else if (adv) begin
            s1_valid <= 1'b0;
         end
         if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) out_data <= joined;
         end
      end
   end

`ifdef JOINT_HITCNT_EN
   logic [HCW-1:0] pop;

   always_comb begin
      pop = '0;
      for (int k = 0; k < N; k++) pop = pop + {{(HCW-1){1'b0}}, joined[k]};
   end

   // Loaded alongside out_data so it holds through a stall.
   always_ff @(posedge clk) begin
      if (rst)                  hit_count <= '0;
      else if (adv && s1_valid) hit_count <= pop;
   end
`else
   assign hit_count = '0;
`endif

endmodule

// File: doc/joint_array.md
JOINT_ARRAY -- requirements
Module: joint_array

Interface
REQ-001 Parameter W, default 38: bits per row; legal range 4..64.
REQ-002 Parameter ROWS, default 2: number of rows; legal range 2..8.
REQ-003 Parameter HEADER, default 16'hAAAA: arming pattern.
REQ-004 Parameter ONESHOT, default 1: 1 disarms after each output transfer; 0 stays armed.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 header_in  in  16  header word, compared every cycle.
REQ-008 in_valid  in  1  in_data valid.
REQ-009 in_ready  out  1  block accepts in_data.
REQ-010 in_data  in  ROWS*W  row r occupies bits [r*W +: W].
REQ-011 out_valid  out  1  out_data valid.
REQ-012 out_ready  in  1  downstream accepts out_data.
REQ-013 out_data  out  ROWS*W  joined rows, same packing as in_data.
REQ-014 armed  out  1  block is armed.
REQ-015 hit_count  out  $clog2(ROWS*W+1)  popcount of out_data (see Configuration).

Function
REQ-016 The block SHALL have two states: IDLE (armed=0) and ARMED (armed=1); IDLE->ARMED when header_in==HEADER.
REQ-017 In IDLE, in_ready SHALL be 0; in_data SHALL be ignored.
REQ-018 A header match while ARMED SHALL have no effect.
REQ-019 In ARMED, in_ready SHALL equal (!s1_valid || adv), where adv = (!out_valid || out_ready).
REQ-020 A transfer SHALL occur when in_valid && in_ready; data is registered into stage 1.
REQ-021 Stage 1 advances to the output register when adv; out_valid=1 exactly two cycles after the transfer cycle if not stalled.
REQ-022 For each pair (r, r+1) and each i in 1..W-2: if row r bit i and row r+1 bit i+1 are set, set row r bit i+1 and row r+1 bit i; if row r bit i+1 and row r+1 bit i are set, set row r bit i and row r+1 bit i+1.
REQ-023 Fills SHALL be computed from stage-1 data only; out_data = input OR all fills, with no iterative propagation.
REQ-024 Bit 0 of every row SHALL pass through unmodified and never trigger or receive a fill.
REQ-025 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-026 With ONESHOT=1: after one transfer, in_ready=0 until the output transfer; the output transfer (out_valid && out_ready) then returns the block to IDLE.
REQ-027 With ONESHOT=1: a header match in the same cycle as that output transfer SHALL leave the block ARMED.
REQ-028 With ONESHOT=0: the block SHALL stay ARMED and sustain one vector per cycle while out_ready=1.

Reset
REQ-029 On rst: state=IDLE, armed=0, in_ready=0, out_valid=0, out_data=0, hit_count=0, stage-1 contents and valid cleared.
REQ-030 rst SHALL dominate header match and handshakes in the same cycle; in-flight data is discarded.

Configuration
REQ-031 With JOINT_HITCNT_EN defined, hit_count SHALL be the popcount of out_data, registered with out_data and stable under stall.
REQ-032 Without JOINT_HITCNT_EN, the hit_count port SHALL exist and be tied to 0 with no popcount logic.

Verification (W=38, ROWS=2, HEADER=16'hAAAA)
REQ-033 No header, in_valid=1 for 10 cycles -> in_ready=0, out_valid stays 0.
REQ-034 Header, then row0=bit5, row1=bit6 -> out row0=bits5,6 and row1=bits5,6, two cycles after transfer; hit_count=4 with JOINT_HITCNT_EN.
REQ-035 row0=bit0, row1=bit1 -> output equals input, no fill; row0=bit36, row1=bit37 -> row0 bit37 and row1 bit36 filled.
REQ-036 ONESHOT=1, out_ready=0 for 5 cycles -> out_data held, in_ready=0; out_ready=1 -> one transfer, armed=0.
REQ-037 ONESHOT=0, ROWS=3, 8 back-to-back vectors with out_ready=1 -> 8 outputs on consecutive cycles, in order; correct fills for pairs (0,1) and (1,2).
REQ-038 rst asserted while out_valid=1 -> next cycle out_valid=0, out_data=0, armed=0.
